// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for the memory stage, directly upstream of the data cache.
// Takes one load or store per request handshake, rejects misaligned accesses
// without touching the cache, holds the cache request stable until the cache
// reports a hit or a write completion, extends load data and returns a response.
module mem_lsu #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wrn,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_misaligned,
    output logic                  resp_is_store,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic [DATA_WIDTH-1:0] dc_wdata,
    output logic [1:0]            dc_wlen,
    output logic                  dc_enable,
    output logic                  dc_wrn,
    input  logic [DATA_WIDTH-1:0] dc_rdata,
    input  logic                  dc_valid,
    input  logic                  dc_write_done,
    output logic [31:0]           stall_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    accept_s;
    logic                    mis_s;
    logic                    done_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [1:0]              size_r;
    logic                    unsigned_r;
    logic                    wrn_r;
    logic [TAG_WIDTH-1:0]    tag_r;
    logic                    mis_r;
    logic                    kill_r;
    logic [DATA_WIDTH-1:0]   resp_data_r;
    logic [31:0]             stall_r;

    // An access is misaligned when any address bit below the access size is set.
    function automatic logic is_misaligned(input logic [2:0] lane, input logic [1:0] size);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lane[0];
            2'd2:    mis = |lane[1:0];
            default: mis = |lane[2:0];
        endcase
        return mis;
    endfunction

    // Pick the addressed field out of the cache word and sign/zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] word,
                                                           input logic [2:0] lane,
                                                           input logic [1:0] size,
                                                           input logic uns);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            2'd0:    res = {{(DATA_WIDTH-8){~uns & sh[7]}}, sh[7:0]};
            2'd1:    res = {{(DATA_WIDTH-16){~uns & sh[15]}}, sh[15:0]};
            2'd2:    res = {{(DATA_WIDTH-32){~uns & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Handshake is closed while in reset and while a flush is active, so a
    // flushed cycle never looks like an accepted request to the pipeline.
    assign req_ready = reset & ~flush & ((state_r == IDLE) | ((state_r == RESP) & resp_ready));
    assign accept_s  = req_valid & req_ready;
    assign mis_s     = is_misaligned(req_addr[2:0], req_size);
    assign done_s    = wrn_r ? dc_write_done : dc_valid;

    assign dc_enable       = (state_r == ACCESS);
    assign dc_addr         = addr_r;
    assign dc_wdata        = wdata_r;
    assign dc_wlen         = size_r;
    assign dc_wrn          = wrn_r;
    assign resp_valid      = (state_r == RESP);
    assign resp_data       = resp_data_r;
    assign resp_tag        = tag_r;
    assign resp_misaligned = mis_r;
    assign resp_is_store   = wrn_r;
    assign stall_cycles    = stall_r;

    // Next-state decode; flush wins over hits and over a same-cycle accept.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = mis_s ? RESP : ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                if (wrn_r) begin
                    // A store cannot be aborted: wait for the write, then drop the response if flushed.
                    if (dc_write_done) begin
                        next_state_s = (kill_r | flush) ? IDLE : RESP;
                    end else begin
                        next_state_s = ACCESS;
                    end
                end else if (flush) begin
                    next_state_s = IDLE;
                end else if (dc_valid) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            RESP: begin
                if (flush) begin
                    next_state_s = IDLE;
                end else if (resp_ready) begin
                    if (accept_s) begin
                        next_state_s = mis_s ? RESP : ACCESS;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture registers; they drive the cache and response fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r     <= '0;
            wdata_r    <= '0;
            size_r     <= 2'd0;
            unsigned_r <= 1'b0;
            wrn_r      <= 1'b0;
            tag_r      <= '0;
            mis_r      <= 1'b0;
        end else if (accept_s) begin
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            wrn_r      <= req_wrn;
            tag_r      <= req_tag;
            mis_r      <= mis_s;
        end else begin
            addr_r     <= addr_r;
        end
    end

    // Remembers a flush that arrived while a store was still waiting for the cache.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kill_r <= 1'b0;
        end else if (accept_s) begin
            kill_r <= 1'b0;
        end else if ((state_r == ACCESS) && wrn_r && flush) begin
            kill_r <= 1'b1;
        end else begin
            kill_r <= kill_r;
        end
    end

    // Response data: cleared on accept (stores and misaligned return 0), loaded on a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_data_r <= '0;
        end else if (accept_s) begin
            resp_data_r <= '0;
        end else if ((state_r == ACCESS) && !wrn_r && dc_valid && !flush) begin
            resp_data_r <= extract_load(dc_rdata, addr_r[2:0], size_r, unsigned_r);
        end else begin
            resp_data_r <= resp_data_r;
        end
    end

    // Saturating count of ACCESS cycles that ended without the cache completing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_r <= 32'd0;
        end else if ((state_r == ACCESS) && !done_s && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed test-plan cases plus randomized transactions, checked
// against a transaction-level reference model of the load/store unit.
module tb_mem_lsu;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_wrn;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_misaligned;
    logic        resp_is_store;
    logic [63:0] dc_addr;
    logic [63:0] dc_wdata;
    logic [1:0]  dc_wlen;
    logic        dc_enable;
    logic        dc_wrn;
    logic [63:0] dc_rdata;
    logic        dc_valid;
    logic        dc_write_done;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference-model expectations for the transaction in flight.
    logic        exp_mis;
    logic        exp_wrn;
    logic [4:0]  exp_tag;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [1:0]  exp_size;
    logic        exp_uns;
    logic [63:0] exp_data;
    longint      exp_stall = 0;

    mem_lsu dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_wrn(req_wrn),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_misaligned(resp_misaligned), .resp_is_store(resp_is_store),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wlen(dc_wlen), .dc_enable(dc_enable),
        .dc_wrn(dc_wrn), .dc_rdata(dc_rdata), .dc_valid(dc_valid),
        .dc_write_done(dc_write_done), .stall_cycles(stall_cycles)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load result from plain arithmetic: shift the addressed bytes down, mask, extend.
    function automatic logic [63:0] ext_model(input logic [63:0] w, input logic [63:0] a,
                                              input logic [1:0] s, input logic u);
        int          nbits;
        logic [63:0] v;
        logic [63:0] m;
        nbits = 8 * (1 << s);
        v = w >> (8 * int'(a % 64'd8));
        if (s == 2'd3) return v;
        m = (64'd1 << nbits) - 64'd1;
        v = v & m;
        if (!u && v[nbits-1]) v = v | ~m;
        return v;
    endfunction

    task automatic drive_req(input logic wrn, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [1:0] size, input logic uns, input logic [4:0] tag);
        req_valid    = 1'b1;
        req_wrn      = wrn;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_tag      = tag;
        exp_wrn      = wrn;
        exp_addr     = addr;
        exp_wdata    = wdata;
        exp_size     = size;
        exp_uns      = uns;
        exp_tag      = tag;
        exp_mis      = (addr % (64'd1 << size)) != 64'd0;
        exp_data     = 64'd0;
    endtask

    // Serve the cache side: lat miss cycles, then one completing cycle.
    task automatic access_phase(input int lat, input logic [63:0] rdata);
        int en;
        en = 0;
        if (exp_mis) begin
            chk("mis_no_dc", 64'(dc_enable), 64'd0);
            exp_data = 64'd0;
        end else begin
            for (int k = 0; k <= lat; k++) begin
                dc_rdata = {$urandom, $urandom};
                if (k == lat) begin
                    dc_rdata = rdata;
                    if (exp_wrn) dc_write_done = 1'b1;
                    else dc_valid = 1'b1;
                end
                #1;
                en += int'(dc_enable);
                chk("dc_addr", dc_addr, exp_addr);
                chk("dc_wrn", 64'(dc_wrn), 64'(exp_wrn));
                chk("dc_wlen", 64'(dc_wlen), 64'(exp_size));
                if (exp_wrn) chk("dc_wdata", dc_wdata, exp_wdata);
                step();
            end
            dc_valid      = 1'b0;
            dc_write_done = 1'b0;
            chk("en_cycles", 64'(en), 64'(lat + 1));
            chk("dc_off", 64'(dc_enable), 64'd0);
            exp_stall += lat;
            exp_data = exp_wrn ? 64'd0 : ext_model(rdata, exp_addr, exp_size, exp_uns);
        end
    endtask

    // Hold the response for bp cycles, then raise resp_ready (caller takes the edge).
    task automatic resp_phase(input int bp);
        for (int k = 0; k <= bp; k++) begin
            resp_ready = (k == bp);
            #1;
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_data", resp_data, exp_data);
            chk("resp_tag", 64'(resp_tag), 64'(exp_tag));
            chk("resp_mis", 64'(resp_misaligned), 64'(exp_mis));
            chk("resp_store", 64'(resp_is_store), 64'(exp_wrn));
            chk("req_ready_resp", 64'(req_ready), 64'(k == bp));
            if (k != bp) step();
        end
    endtask

    task automatic txn(input logic wrn, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [4:0] tag,
                       input int lat, input logic [63:0] rdata, input int bp);
        drive_req(wrn, addr, wdata, size, uns, tag);
        #1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        access_phase(lat, rdata);
        resp_phase(bp);
        step();
        resp_ready = 1'b0;
        #1;
        chk("resp_done", 64'(resp_valid), 64'd0);
        chk("stall", 64'(stall_cycles), 64'(exp_stall));
    endtask

    initial begin
        int          cnt;
        logic        r_wrn;
        logic [1:0]  r_size;
        logic [63:0] r_addr;
        logic [63:0] r_mask;

        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_wrn = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_size = 2'd0; req_unsigned = 1'b0; req_tag = 5'd0;
        resp_ready = 1'b0; dc_rdata = 64'd0; dc_valid = 1'b0; dc_write_done = 1'b0;
        exp_mis = 1'b0; exp_wrn = 1'b0; exp_tag = 5'd0; exp_addr = 64'd0; exp_wdata = 64'd0;
        exp_size = 2'd0; exp_uns = 1'b0; exp_data = 64'd0;

        // Reset state.
        #22;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_dc_enable", 64'(dc_enable), 64'd0);
        chk("rst_dc_addr", dc_addr, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Aligned load hit, extension cases, misaligned word load.
        txn(1'b0, 64'h1000, 64'd0, 2'd3, 1'b0, 5'd5, 0, 64'h8877665544332211, 0);
        txn(1'b0, 64'h1007, 64'd0, 2'd0, 1'b0, 5'd6, 0, 64'h8000000000000000, 0);
        txn(1'b0, 64'h1007, 64'd0, 2'd0, 1'b1, 5'd7, 0, 64'h8000000000000000, 0);
        txn(1'b0, 64'h1002, 64'd0, 2'd1, 1'b0, 5'd8, 1, 64'h0000000080010000, 0);
        txn(1'b0, 64'h1006, 64'd0, 2'd2, 1'b0, 5'd9, 0, 64'd0, 0);

        // Store with a 20-cycle miss.
        txn(1'b1, 64'h2000, 64'hDEADBEEF, 2'd3, 1'b0, 5'd10, 20, 64'd0, 0);

        // Backpressure for 5 cycles, then back-to-back accept on the releasing edge.
        drive_req(1'b0, 64'h3000, 64'd0, 2'd3, 1'b0, 5'd11);
        step();
        req_valid = 1'b0;
        access_phase(0, 64'h0123456789ABCDEF);
        resp_phase(5);
        drive_req(1'b0, 64'h3004, 64'd0, 2'd2, 1'b0, 5'd12);
        #1;
        chk("b2b_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        resp_ready = 1'b0;
        #1;
        chk("b2b_resp_off", 64'(resp_valid), 64'd0);
        chk("b2b_access", 64'(dc_enable), 64'd1);
        access_phase(2, 64'hF00DCAFE12345678);
        resp_phase(0);
        step();
        resp_ready = 1'b0;
        #1;
        chk("b2b_done", 64'(resp_valid), 64'd0);
        chk("b2b_stall", 64'(stall_cycles), 64'(exp_stall));

        // Flush of a load in ACCESS: no response, back to idle.
        drive_req(1'b0, 64'h4000, 64'd0, 2'd3, 1'b0, 5'd13);
        step();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_ld_en", 64'(dc_enable), 64'd1);
        step();
        flush = 1'b0;
        exp_stall += 1;
        #1;
        chk("fl_ld_dc_off", 64'(dc_enable), 64'd0);
        chk("fl_ld_no_resp", 64'(resp_valid), 64'd0);
        chk("fl_ld_idle", 64'(req_ready), 64'd1);

        // Flush of a store in ACCESS: the write still completes, once, with no response.
        drive_req(1'b1, 64'h4008, 64'h55AA, 2'd3, 1'b0, 5'd14);
        step();
        req_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            flush = (k == 0);
            dc_write_done = (k == 3);
            #1;
            cnt += int'(dc_enable);
            step();
        end
        flush = 1'b0;
        dc_write_done = 1'b0;
        exp_stall += 3;
        chk("fl_st_en_cycles", 64'(cnt), 64'd4);
        chk("fl_st_dc_off", 64'(dc_enable), 64'd0);
        chk("fl_st_no_resp", 64'(resp_valid), 64'd0);
        step();
        chk("fl_st_no_resp2", 64'(resp_valid), 64'd0);
        chk("fl_st_stall", 64'(stall_cycles), 64'(exp_stall));

        // Flush in RESP drops the response.
        drive_req(1'b0, 64'h4010, 64'd0, 2'd3, 1'b0, 5'd15);
        step();
        req_valid = 1'b0;
        access_phase(1, 64'h1);
        flush = 1'b1;
        #1;
        chk("fl_rsp_valid", 64'(resp_valid), 64'd1);
        step();
        flush = 1'b0;
        #1;
        chk("fl_rsp_dropped", 64'(resp_valid), 64'd0);

        // Flush in IDLE blocks a same-cycle request.
        drive_req(1'b0, 64'h4018, 64'd0, 2'd3, 1'b0, 5'd16);
        flush = 1'b1;
        step();
        req_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("fl_idle_no_dc", 64'(dc_enable), 64'd0);
        chk("fl_idle_no_resp", 64'(resp_valid), 64'd0);

        // Flush in RESP wins over a same-cycle accept.
        drive_req(1'b0, 64'h4020, 64'd0, 2'd3, 1'b0, 5'd17);
        step();
        req_valid = 1'b0;
        access_phase(0, 64'h2);
        resp_ready = 1'b1;
        flush = 1'b1;
        drive_req(1'b0, 64'h4028, 64'd0, 2'd3, 1'b0, 5'd18);
        step();
        req_valid = 1'b0;
        flush = 1'b0;
        resp_ready = 1'b0;
        #1;
        chk("fl_prio_no_dc", 64'(dc_enable), 64'd0);
        chk("fl_prio_no_resp", 64'(resp_valid), 64'd0);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            r_wrn  = 1'($urandom % 2);
            r_size = 2'($urandom % 4);
            r_addr = {$urandom, $urandom};
            if (($urandom % 4) != 0) begin
                r_mask = (64'd1 << r_size) - 64'd1;
                r_addr = r_addr & ~r_mask;
            end
            txn(r_wrn, r_addr, {$urandom, $urandom}, r_size, 1'($urandom % 2), 5'($urandom),
                int'($urandom % 5), {$urandom, $urandom}, int'($urandom % 4));
        end

        // Asynchronous reset in the middle of ACCESS.
        drive_req(1'b0, 64'h5000, 64'd0, 2'd3, 1'b0, 5'd19);
        step();
        req_valid = 1'b0;
        #1;
        chk("ar_en_before", 64'(dc_enable), 64'd1);
        reset = 1'b0;
        #1;
        exp_stall = 0;
        chk("ar_dc_enable", 64'(dc_enable), 64'd0);
        chk("ar_dc_addr", dc_addr, 64'd0);
        chk("ar_resp_valid", 64'(resp_valid), 64'd0);
        chk("ar_resp_tag", 64'(resp_tag), 64'd0);
        chk("ar_req_ready", 64'(req_ready), 64'd0);
        chk("ar_stall", 64'(stall_cycles), 64'(exp_stall));
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("ar_idle", 64'(req_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
